// File: rtl/xbar_cfg_loader.sv
// Crossbar select-bus loader: streams config words into a shadow image, range-checks every
// select field, and only then commits the image to the live io_mux_configs bus.
module xbar_cfg_loader #(
    parameter int NUM_INS  = 27,
    parameter int NUM_OUTS = 32,
    parameter int SEL_BITS = 5,
    parameter int WORD_W   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_start,
    input  logic                            cfg_valid,
    input  logic [WORD_W-1:0]               cfg_word,
    output logic                            cfg_ready,
    output logic                            cfg_busy,
    output logic                            cfg_done,
    output logic                            cfg_err,
    output logic [$clog2(NUM_OUTS)-1:0]     err_index,
    output logic [NUM_OUTS*SEL_BITS-1:0]    io_mux_configs
);

    localparam int CFG_W     = NUM_OUTS * SEL_BITS;
    localparam int NUM_WORDS = (CFG_W + WORD_W - 1) / WORD_W;
    localparam int SHW_W     = NUM_WORDS * WORD_W;
    localparam int WCNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int IDX_W     = $clog2(NUM_OUTS);

    localparam logic [WCNT_W-1:0]   LAST_WORD  = WCNT_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0]    LAST_FIELD = IDX_W'(NUM_OUTS - 1);
    localparam logic [SEL_BITS:0]   SEL_LIMIT  = (SEL_BITS + 1)'(NUM_INS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_COMMIT
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [SHW_W-1:0]       r_shadow;
    logic [CFG_W-1:0]       r_bus;
    logic [WCNT_W-1:0]      r_wcnt;
    logic [IDX_W-1:0]       r_fidx;
    logic                   r_done;
    logic                   r_err;
    logic [IDX_W-1:0]       r_err_index;

    logic                   w_restart;
    logic                   w_accept;
    logic                   w_field_step;
    logic                   w_fail;
    logic                   w_commit;
    logic [SEL_BITS-1:0]    w_field;
    logic                   w_field_bad;

    assign w_field     = r_shadow[r_fidx*SEL_BITS +: SEL_BITS];
    assign w_field_bad = ({1'b0, w_field} >= SEL_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        cfg_ready    = 1'b0;
        w_restart    = 1'b0;
        w_accept     = 1'b0;
        w_field_step = 1'b0;
        w_fail       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    w_restart    = 1'b1;
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                cfg_ready = 1'b1;
                // A restart wins over a word arriving in the same cycle.
                if (cfg_start) begin
                    w_restart = 1'b1;
                end else if (cfg_valid) begin
                    w_accept = 1'b1;
                    if (r_wcnt == LAST_WORD) begin
                        w_next_state = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (cfg_start) begin
                    w_restart    = 1'b1;
                    w_next_state = S_LOAD;
                end else if (w_field_bad) begin
                    w_fail       = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_field_step = 1'b1;
                    if (r_fidx == LAST_FIELD) begin
                        w_next_state = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                w_commit     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow    <= '0;
            r_bus       <= '0;
            r_wcnt      <= '0;
            r_fidx      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_index <= '0;
        end else begin
            r_done <= w_commit;
            if (w_restart) begin
                r_wcnt      <= '0;
                r_fidx      <= '0;
                r_err       <= 1'b0;
                r_err_index <= '0;
            end
            if (w_accept) begin
                r_shadow[r_wcnt*WORD_W +: WORD_W] <= cfg_word;
                r_wcnt                            <= r_wcnt + WCNT_W'(1);
            end
            if (w_field_step) begin
                r_fidx <= r_fidx + IDX_W'(1);
            end
            if (w_fail) begin
                r_err       <= 1'b1;
                r_err_index <= r_fidx;
            end
            // Done and the new bus land on the same edge.
            if (w_commit) begin
                r_bus <= r_shadow[CFG_W-1:0];
            end
        end
    end

    assign cfg_busy       = (r_state != S_IDLE);
    assign cfg_done       = r_done;
    assign cfg_err        = r_err;
    assign err_index      = r_err_index;
    assign io_mux_configs = r_bus;

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// Randomized bench for xbar_cfg_loader: a field-level reference model predicts commit/error,
// latency and the resulting crossbar routing for each load.
module tb_xbar_cfg_loader;

    localparam int NI = 27;
    localparam int NO = 32;
    localparam int SB = 5;
    localparam int WW = 16;
    localparam int CW = NO * SB;
    localparam int NW = (CW + WW - 1) / WW;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_start;
    logic              cfg_valid;
    logic [WW-1:0]     cfg_word;
    logic              cfg_ready;
    logic              cfg_busy;
    logic              cfg_done;
    logic              cfg_err;
    logic [4:0]        err_index;
    logic [CW-1:0]     io_mux_configs;

    xbar_cfg_loader dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_start      (cfg_start),
        .cfg_valid      (cfg_valid),
        .cfg_word       (cfg_word),
        .cfg_ready      (cfg_ready),
        .cfg_busy       (cfg_busy),
        .cfg_done       (cfg_done),
        .cfg_err        (cfg_err),
        .err_index      (err_index),
        .io_mux_configs (io_mux_configs)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    int            ncyc;
    logic [CW-1:0] exp_bus;
    int            fld[NO];
    int            junk[NO];

    task automatic chk(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] pack(input int f[NO]);
        logic [CW-1:0] img;
        img = '0;
        for (int i = 0; i < NO; i++) img[i*SB +: SB] = SB'(f[i]);
        return img;
    endfunction

    function automatic int first_bad(input int f[NO]);
        for (int i = 0; i < NO; i++) if (f[i] >= NI) return i;
        return -1;
    endfunction

    task automatic rand_legal(output int f[NO]);
        for (int i = 0; i < NO; i++) f[i] = int'($urandom_range(0, NI - 1));
    endtask

    // Routing seen by the crossbar: output o carries input f[o].
    task automatic mux_check(input int f[NO]);
        logic [NI-1:0] xin;
        logic [NO-1:0] exp_o;
        logic [NO-1:0] act_o;
        logic [SB-1:0] sel;
        xin = NI'($urandom);
        for (int o = 0; o < NO; o++) begin
            exp_o[o] = xin[f[o]];
            sel      = io_mux_configs[o*SB +: SB];
            act_o[o] = (sel < SB'(NI)) ? xin[sel] : 1'bx;
        end
        chk("mux_out", CW'(act_o), CW'(exp_o));
    endtask

    task automatic start_pulse(input bit dirty);
        cfg_start = 1'b1;
        cfg_valid = dirty;
        cfg_word  = WW'($urandom);
        if (dirty) chk("idle_ready", CW'(cfg_ready), CW'(0));
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic send_words(input logic [CW-1:0] img, input int nwords, input int gap);
        bit acc;
        int guard;
        for (int k = 0; k < nwords; k++) begin
            guard = 0;
            do begin
                cfg_valid = ($urandom_range(0, 99) >= gap);
                cfg_word  = cfg_valid ? img[k*WW +: WW] : WW'($urandom);
                acc       = cfg_valid && cfg_ready;
                tick();
                ncyc++;
                guard++;
                chk("stable_load", io_mux_configs, exp_bus);
            end while (!acc && guard < 200);
            if (!acc) chk("word_timeout", CW'(0), CW'(1));
        end
        cfg_valid = 1'b0;
    endtask

    task automatic run_load(input int f[NO], input int gap, input bit dirty);
        logic [CW-1:0] img;
        int bad;
        int last;
        int done_n;
        int guard;
        img = pack(f);
        bad = first_bad(f);
        start_pulse(dirty);
        ncyc = 0;
        chk("busy_start", CW'(cfg_busy), CW'(1));
        chk("err_clr", CW'(cfg_err), CW'(0));
        chk("ready_load", CW'(cfg_ready), CW'(1));
        send_words(img, NW, gap);
        last   = ncyc;
        done_n = -1;
        guard  = 0;
        while (cfg_busy && guard < 100) begin
            tick();
            ncyc++;
            guard++;
            if (cfg_done) done_n = ncyc;
            else chk("stable_wait", io_mux_configs, exp_bus);
        end
        if (cfg_busy) chk("busy_timeout", CW'(1), CW'(0));
        if (bad < 0) begin
            // Check runs one cycle per field, then one commit cycle.
            chk("done_lat", CW'(done_n), CW'(last + NO + 1));
            // Counting the cfg_start cycle as cycle 1, done shows in cycle 44.
            if (gap == 0) chk("lat44", CW'(done_n + 1), CW'(44));
            chk("bus_commit", io_mux_configs, img);
            chk("err_low", CW'(cfg_err), CW'(0));
            exp_bus = img;
            mux_check(f);
            tick();
            chk("done_pulse", CW'(cfg_done), CW'(0));
        end else begin
            chk("no_done", CW'(done_n), CW'(-1));
            chk("err_high", CW'(cfg_err), CW'(1));
            chk("err_index", CW'(err_index), CW'(bad));
            chk("check_len", CW'(ncyc - last), CW'(bad + 1));
            chk("bus_keep", io_mux_configs, exp_bus);
        end
    endtask

    initial begin
        bit saw_done;
        reset     = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_word  = '0;
        exp_bus   = '0;
        #1;
        chk("rst_bus", io_mux_configs, CW'(0));
        chk("rst_flags", CW'({cfg_ready, cfg_busy, cfg_done, cfg_err}), CW'(0));
        chk("rst_idx", CW'(err_index), CW'(0));
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Reset in the middle of a load: nothing commits.
        rand_legal(fld);
        start_pulse(1'b0);
        send_words(pack(fld), 4, 0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy", CW'(cfg_busy), CW'(0));
        chk("midrst_ready", CW'(cfg_ready), CW'(0));
        chk("midrst_bus", io_mux_configs, CW'(0));
        repeat (2) tick();
        reset    = 1'b1;
        saw_done = 1'b0;
        repeat (50) begin
            tick();
            if (cfg_done || cfg_busy) saw_done = 1'b1;
        end
        chk("midrst_quiet", CW'(saw_done), CW'(0));

        // Field i = i mod 27, back to back.
        for (int i = 0; i < NO; i++) fld[i] = i % NI;
        run_load(fld, 0, 1'b0);
        chk("f0", CW'(io_mux_configs[4:0]), CW'(0));
        chk("f27", CW'(io_mux_configs[139:135]), CW'(0));
        chk("f31", CW'(io_mux_configs[159:155]), CW'(4));

        // Field 5 out of range.
        rand_legal(fld);
        fld[5] = 27;
        run_load(fld, 0, 1'b0);

        // Gappy valid, start coinciding with valid in IDLE.
        for (int r = 0; r < 4; r++) begin
            rand_legal(fld);
            run_load(fld, 50, r[0]);
        end

        // Restart after 4 words.
        rand_legal(junk);
        start_pulse(1'b0);
        send_words(pack(junk), 4, 0);
        rand_legal(fld);
        run_load(fld, 0, 1'b0);

        // Restart while checking a complete image.
        rand_legal(junk);
        start_pulse(1'b0);
        send_words(pack(junk), NW, 0);
        repeat (5) begin
            tick();
            chk("stable_chk", io_mux_configs, exp_bus);
        end
        rand_legal(fld);
        run_load(fld, 30, 1'b0);

        // Last field illegal, then a clean reload.
        rand_legal(fld);
        fld[31] = 31;
        run_load(fld, 20, 1'b0);
        rand_legal(fld);
        run_load(fld, 0, 1'b0);

        // A few random images, some with an illegal field.
        for (int r = 0; r < 4; r++) begin
            rand_legal(fld);
            if (r[0]) fld[$urandom_range(0, NO - 1)] = int'($urandom_range(NI, 31));
            run_load(fld, 25, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
